// File: rtl/dmem_pkg.sv
// Shared types and constants for the byte-lane data memory.
package dmem_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int BYTE_W      = 8;
  localparam int PRELOAD_LEN = 10;

  localparam logic [BYTE_W-1:0] PRELOAD_BYTES [PRELOAD_LEN] = '{
    8'h2B, 8'hCD, 8'h00, 8'h00, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF
  };

  // Big-endian: the byte at word offset k sits in the lane starting at this bit.
  function automatic int lane_lsb(input int bpw, input int k);
    return BYTE_W * (bpw - 1 - k);
  endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// Request/response bus of the data memory; the CPU side is master, the memory is slave.
interface dmem_bytelane_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  localparam int BPW = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BPW-1:0]    req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/dmem_lane_array.sv
// Word-organised storage with one write enable per byte lane and a registered read port.
module dmem_lane_array
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = 12,
  localparam int BPW        = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic [BPW-1:0]    we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [BPW-1:0][BYTE_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0]          rdata_q;

  // NOTE: storage has no reset term so it maps onto RAM; the clear sequencer initialises it.
  // NOTE: non-blocking assignments keep the read seeing pre-edge contents like a real flop/RAM.
  always_ff @(posedge clk) begin
    for (int j = 0; j < BPW; j++) begin
      if (we_i[j]) begin
        mem_q[addr_i][j] <= wdata_i[j*BYTE_W +: BYTE_W];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed big-endian data memory: clear FSM, request checking and response registers.
// Build option: define DMEM_PRELOAD_EN to seed bytes 0..9 during the clear sequence.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 4096
) (
  input logic            clk,
  input logic            rst,
  dmem_bytelane_if.slave bus
);

  localparam int BPW   = DATA_W / BYTE_W;
  localparam int OFF_W = $clog2(BPW);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  clr_cnt_q;
  logic              busy_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              rsp_rd_q;

  logic [ADDR_W-1:0] word_idx;
  logic              misaligned;
  logic              in_range;
  logic              accept;
  logic              req_ok;
  logic [DATA_W-1:0] init_word;

  logic [BPW-1:0]    arr_we;
  logic [IDX_W-1:0]  arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic              arr_re;
  logic [DATA_W-1:0] arr_rdata;

  assign word_idx   = bus.req_addr >> OFF_W;
  assign misaligned = |bus.req_addr[OFF_W-1:0];
  assign in_range   = word_idx < ADDR_W'(DEPTH_WORDS);
  // A request held across a reset edge must never reach the array.
  assign accept     = bus.req_valid && ready_q && !rst;
  assign req_ok     = accept && !misaligned && in_range;

  always_comb begin
    init_word = '0;
`ifdef DMEM_PRELOAD_EN
    for (int p = 0; p < PRELOAD_LEN; p++) begin
      if (p / BPW == int'(clr_cnt_q)) begin
        init_word[lane_lsb(BPW, p % BPW) +: BYTE_W] = PRELOAD_BYTES[p];
      end
    end
`endif
  end

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    arr_we    = '0;
    arr_re    = 1'b0;
    arr_addr  = word_idx[IDX_W-1:0];
    arr_wdata = bus.req_wdata;
    if (!rst && state_q == CLEAR) begin
      arr_we    = '1;
      arr_addr  = clr_cnt_q;
      arr_wdata = init_word;
    end else if (req_ok) begin
      if (bus.req_we) begin
        arr_we = bus.req_be;
      end else begin
        arr_re = 1'b1;
      end
    end
  end

  dmem_lane_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .re_i    (arr_re),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      busy_q      <= 1'b1;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          if (clr_cnt_q == LAST_IDX) begin
            state_q <= READY;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + IDX_W'(1);
          end
        end
        READY: ;
        default: state_q <= CLEAR;
      endcase
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && !req_ok;
      rsp_rd_q    <= req_ok && !bus.req_we;
    end
  end

  // Read data only shows through for a successful read; writes and errors return zero.
  assign bus.rsp_rdata = rsp_rd_q ? arr_rdata : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;

endmodule
